// File: rtl/te_fifo_reader.sv
// Reads one block per channel from a rewindable sample FIFO and streams it to the
// correlator: read, receive, rewind for the next channel, skip after the last one.
module te_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int CH_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  te_enable,
  input  logic                  fifo_clear,
  input  logic [CH_WIDTH:0]     channel_count,
  input  logic [ADDR_WIDTH-1:0] block_size,
  input  logic                  fifo_ready,
  input  logic                  fifo_data_valid,
  input  logic                  fifo_last_data,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  fifo_rewind,
  output logic                  fifo_skip,
  input  logic                  corr_busy,
  output logic                  ch_start,
  output logic [CH_WIDTH-1:0]   ch_index,
  output logic                  corr_valid,
  output logic [DATA_WIDTH-1:0] corr_data,
  output logic                  corr_last,
  output logic [15:0]           block_count,
  output logic                  len_error,
  input  logic                  err_clear,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_READY = 3'd1;
  localparam logic [2:0] S_REQUEST    = 3'd2;
  localparam logic [2:0] S_RECEIVE    = 3'd3;
  localparam logic [2:0] S_POST       = 3'd4;
  localparam logic [2:0] S_REWIND     = 3'd5;
  localparam logic [2:0] S_SKIP       = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_W = 1;
  localparam logic [CH_WIDTH:0]     CH_ONE_W  = 1;

  // FIFO handshake: a sample is transferred on every cycle fifo_data_valid is high
  // while in RECEIVE (no back-pressure); fifo_last_data qualifies the final one.
  // Commands (read/rewind/skip) are single-cycle pulses, never two at once.

  logic [2:0]            state_q, state_d;
  logic [CH_WIDTH-1:0]   ch_index_q, ch_index_d;
  logic [CH_WIDTH:0]     ch_count_q, ch_count_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]           block_count_q, block_count_d;
  logic                  len_error_q, len_error_d;
  logic                  fifo_read_q, fifo_read_d;
  logic                  fifo_rewind_q, fifo_rewind_d;
  logic                  fifo_skip_q, fifo_skip_d;
  logic                  ch_start_q, ch_start_d;
  logic                  corr_valid_q, corr_valid_d;
  logic                  corr_last_q, corr_last_d;
  logic [DATA_WIDTH-1:0] corr_data_q, corr_data_d;

  logic abort;
  logic rx_last;
  logic last_ch;

  always_comb begin
    abort   = fifo_clear | ~te_enable;
    rx_last = (state_q == S_RECEIVE) && fifo_data_valid && fifo_last_data;
    last_ch = ({1'b0, ch_index_q} + CH_ONE_W) >= ch_count_q;

    state_d       = state_q;
    ch_index_d    = ch_index_q;
    ch_count_d    = ch_count_q;
    cnt_d         = cnt_q;
    block_count_d = block_count_q;
    len_error_d   = err_clear ? 1'b0 : len_error_q;

    case (state_q)
      S_IDLE: begin
        if (channel_count != '0) state_d = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        ch_count_d = channel_count;
        if (channel_count == '0) state_d = S_IDLE;
        else if (fifo_ready)     state_d = S_REQUEST;
      end
      S_REQUEST: begin
        cnt_d   = '0;
        state_d = S_RECEIVE;
      end
      S_RECEIVE: begin
        if (fifo_data_valid) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
        if (rx_last) begin
          state_d = S_POST;
          // Length mismatch is flagged but the block still completes normally.
          if (({1'b0, cnt_q} + CNT_ONE_W) != {1'b0, block_size} && !abort)
            len_error_d = 1'b1;
        end
      end
      S_POST: begin
        if (!corr_busy) state_d = last_ch ? S_SKIP : S_REWIND;
      end
      S_REWIND: begin
        ch_index_d = ch_index_q + 1'b1;
        state_d    = S_REQUEST;
      end
      S_SKIP: begin
        state_d = S_WAIT_READY;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;
    if (state_d == S_IDLE || state_d == S_WAIT_READY) ch_index_d = '0;
    if (state_d == S_SKIP) block_count_d = block_count_q + 16'd1;

    // Command pulses are registered copies of the state being entered.
    fifo_read_d   = (state_d == S_REQUEST);
    ch_start_d    = (state_d == S_REQUEST);
    fifo_rewind_d = (state_d == S_REWIND);
    fifo_skip_d   = (state_d == S_SKIP);

    corr_valid_d = (state_q == S_RECEIVE) && fifo_data_valid && !abort;
    corr_last_d  = rx_last && !abort;
    corr_data_d  = fifo_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= S_IDLE;
      ch_index_q    <= '0;
      ch_count_q    <= '0;
      cnt_q         <= '0;
      block_count_q <= '0;
      len_error_q   <= 1'b0;
      fifo_read_q   <= 1'b0;
      fifo_rewind_q <= 1'b0;
      fifo_skip_q   <= 1'b0;
      ch_start_q    <= 1'b0;
      corr_valid_q  <= 1'b0;
      corr_last_q   <= 1'b0;
      corr_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      ch_index_q    <= ch_index_d;
      ch_count_q    <= ch_count_d;
      cnt_q         <= cnt_d;
      block_count_q <= block_count_d;
      len_error_q   <= len_error_d;
      fifo_read_q   <= fifo_read_d;
      fifo_rewind_q <= fifo_rewind_d;
      fifo_skip_q   <= fifo_skip_d;
      ch_start_q    <= ch_start_d;
      corr_valid_q  <= corr_valid_d;
      corr_last_q   <= corr_last_d;
      corr_data_q   <= corr_data_d;
    end
  end

  assign fifo_read   = fifo_read_q;
  assign fifo_rewind = fifo_rewind_q;
  assign fifo_skip   = fifo_skip_q;
  assign ch_start    = ch_start_q;
  assign ch_index    = ch_index_q;
  assign corr_valid  = corr_valid_q;
  assign corr_data   = corr_data_q;
  assign corr_last   = corr_last_q;
  assign block_count = block_count_q;
  assign len_error   = len_error_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_te_fifo_reader.sv
// Bench for te_fifo_reader: the bench plays the FIFO and correlator, predicts the
// event stream (read/data/rewind/skip) into a queue and checks counters per block.
module tb_te_fifo_reader;

  localparam int DW = 8;
  localparam int AW = 14;
  localparam int CW = 5;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [15:0] EV_REWIND = 16'h8000;
  localparam logic [15:0] EV_SKIP   = 16'hC000;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          te_enable = 1'b0;
  logic          fifo_clear = 1'b0;
  logic [CW:0]   channel_count = '0;
  logic [AW-1:0] block_size = '0;
  logic          fifo_ready = 1'b0;
  logic          fifo_data_valid = 1'b0;
  logic          fifo_last_data = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          corr_busy = 1'b0;
  logic          err_clear = 1'b0;
  logic          fifo_read, fifo_rewind, fifo_skip, ch_start;
  logic [CW-1:0] ch_index;
  logic          corr_valid, corr_last, len_error;
  logic [DW-1:0] corr_data;
  logic [15:0]   block_count;
  logic [2:0]    state_dbg;

  te_fifo_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .clk(clk), .rst_b(rst_b), .te_enable(te_enable), .fifo_clear(fifo_clear),
    .channel_count(channel_count), .block_size(block_size), .fifo_ready(fifo_ready),
    .fifo_data_valid(fifo_data_valid), .fifo_last_data(fifo_last_data),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .fifo_rewind(fifo_rewind),
    .fifo_skip(fifo_skip), .corr_busy(corr_busy), .ch_start(ch_start),
    .ch_index(ch_index), .corr_valid(corr_valid), .corr_data(corr_data),
    .corr_last(corr_last), .block_count(block_count), .len_error(len_error),
    .err_clear(err_clear), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] bc_model = '0;
  logic [DW-1:0] fd_prev = '0;
  logic prev_rst_ok = 1'b0;
  bit clr_with_last = 1'b0;
  bit abort_by_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input logic [15:0] ev);
    logic [15:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event_unexpected: got %04h expected none", ev);
    end else begin
      e = exp_q.pop_front();
      if (ev !== e) begin
        n_err++;
        $display("FAIL event_order: got %04h expected %04h", ev, e);
      end
    end
  endtask

  always @(posedge clk) begin
    fd_prev     <= fifo_data;
    prev_rst_ok <= rst_b;
  end

  always @(negedge clk) begin
    if (rst_b) begin
      if (fifo_read || ch_start) observe({2'b00, ch_index, ch_start, 7'd0, fifo_read});
      if (corr_valid) observe({2'b01, 5'd0, corr_last, corr_data});
      if (fifo_rewind) observe(EV_REWIND);
      if (fifo_skip) observe(EV_SKIP);
      if (prev_rst_ok) check("corr_data_delay", {24'd0, corr_data}, {24'd0, fd_prev});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fifo_read) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL read_timeout: got no fifo_read expected one within 40 cycles");
    end
  endtask

  task automatic run_channel(input int c, input int nsamp, input int busy,
                             input bit last_ch, input int abort_at);
    bit ok;
    logic [DW-1:0] d;
    exp_q.push_back({2'b00, 5'(c), 1'b1, 8'h01});
    wait_read(ok);
    if (!ok) return;
    fifo_ready = 1'b0;
    for (int k = 0; k < nsamp; k++) begin
      tick();
      if ($urandom_range(0, 3) == 0) begin
        fifo_data_valid = 1'b0;
        fifo_data = 8'($urandom);
        tick();
      end
      d = 8'($urandom);
      fifo_data = d;
      fifo_data_valid = 1'b1;
      fifo_last_data = (k == nsamp - 1);
      if (abort_at != 0 && k == abort_at - 1) begin
        if (abort_by_en) te_enable = 1'b0;
        else fifo_clear = 1'b1;
        tick();
        te_enable = 1'b1;
        fifo_clear = 1'b0;
        fifo_data_valid = 1'b0;
        fifo_last_data = 1'b0;
        return;
      end
      exp_q.push_back({2'b01, 5'd0, fifo_last_data, d});
      if (k == nsamp - 1) begin
        if (busy > 0) corr_busy = 1'b1;
        if (clr_with_last) err_clear = 1'b1;
      end
    end
    tick();
    fifo_data_valid = 1'b0;
    fifo_last_data = 1'b0;
    err_clear = 1'b0;
    for (int b = 0; b < busy; b++) tick();
    corr_busy = 1'b0;
    exp_q.push_back(last_ch ? EV_SKIP : EV_REWIND);
    tick();
    if (last_ch) begin
      bc_model = bc_model + 16'd1;
      check("skip_pulse", {31'd0, fifo_skip}, 32'd1);
      check("block_count_at_skip", {16'd0, block_count}, {16'd0, bc_model});
    end else begin
      check("rewind_pulse", {31'd0, fifo_rewind}, 32'd1);
      check("read_with_rewind", {31'd0, fifo_read}, 32'd0);
    end
  endtask

  task automatic run_block(input int nch, input int bsize, input int nsamp, input int busy);
    channel_count = (CW + 1)'(nch);
    block_size = AW'(bsize);
    fifo_ready = 1'b1;
    for (int c = 0; c < nch; c++) run_channel(c, nsamp, busy, c == nch - 1, 0);
  endtask

  task automatic end_block(input bit exp_err);
    tick();
    check("block_count", {16'd0, block_count}, {16'd0, bc_model});
    check("len_error", {31'd0, len_error}, {31'd0, exp_err});
    check("ch_index_idle", {27'd0, ch_index}, 32'd0);
    check("state_wait", {29'd0, state_dbg}, {29'd0, S_WAIT});
    if (exp_err) begin
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("len_error_cleared", {31'd0, len_error}, 32'd0);
    end
  endtask

  typedef struct {
    int nch;
    int bsize;
    int nsamp;
    int busy;
    bit exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit ok;
    tbl[0] = '{3, 16, 16, 0, 1'b0};
    tbl[1] = '{1, 16, 15, 0, 1'b1};
    tbl[2] = '{2, 4, 4, 10, 1'b0};
    tbl[3] = '{4, 1, 1, 2, 1'b0};
    tbl[4] = '{1, 8, 9, 1, 1'b1};
    tbl[5] = '{5, 3, 3, 0, 1'b0};

    // reset state, with data toggling underneath
    repeat (3) begin
      fifo_data = 8'($urandom);
      tick();
    end
    check("reset_flags", {25'd0, fifo_read, fifo_rewind, fifo_skip, ch_start,
                          corr_valid, corr_last, len_error}, 32'd0);
    check("reset_corr_data", {24'd0, corr_data}, 32'd0);
    check("reset_ch_index", {27'd0, ch_index}, 32'd0);
    check("reset_block_count", {16'd0, block_count}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    rst_b = 1'b1;

    // zero channels: must never leave IDLE
    te_enable = 1'b1;
    channel_count = '0;
    fifo_ready = 1'b1;
    repeat (20) tick();
    check("zero_ch_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});
    fifo_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_block(tbl[i].nch, tbl[i].bsize, tbl[i].nsamp, tbl[i].busy);
      end_block(tbl[i].exp_err);
    end

    // err_clear coinciding with a new length error
    clr_with_last = 1'b1;
    run_block(1, 8, 7, 0);
    clr_with_last = 1'b0;
    end_block(1'b1);

    // fifo_clear on the 5th sample of channel 1
    channel_count = 6'd3;
    block_size = 14'd16;
    fifo_ready = 1'b1;
    run_channel(0, 16, 0, 1'b0, 0);
    run_channel(1, 16, 0, 1'b0, 5);
    check("clear_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("clear_corr_valid", {31'd0, corr_valid}, 32'd0);
    check("clear_no_cmd", {30'd0, fifo_rewind, fifo_skip}, 32'd0);
    repeat (6) tick();
    check("clear_block_count", {16'd0, block_count}, {16'd0, bc_model});
    check("clear_queue_empty", exp_q.size(), 32'd0);

    // te_enable dropped on the 2nd sample of channel 0
    abort_by_en = 1'b1;
    channel_count = 6'd2;
    fifo_ready = 1'b1;
    run_channel(0, 8, 0, 1'b0, 2);
    abort_by_en = 1'b0;
    check("disable_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    repeat (4) tick();
    check("disable_block_count", {16'd0, block_count}, {16'd0, bc_model});

    // block counter wrap
    @(negedge clk);
    dut.block_count_q = 16'hFFFF;
    bc_model = 16'hFFFF;
    tick();
    run_block(2, 6, 6, 0);
    end_block(1'b0);
    check("wrap_zero", {16'd0, block_count}, 32'd0);

    // asynchronous reset in the middle of a channel
    channel_count = 6'd2;
    block_size = 14'd8;
    fifo_ready = 1'b1;
    exp_q.push_back({2'b00, 5'd0, 1'b1, 8'h01});
    wait_read(ok);
    fifo_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      fifo_data = 8'($urandom);
      fifo_data_valid = 1'b1;
      if (k < 2) exp_q.push_back({2'b01, 5'd0, 1'b0, fifo_data});
    end
    tick();
    fifo_data_valid = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    check("midrst_flags", {25'd0, fifo_read, fifo_rewind, fifo_skip, ch_start,
                           corr_valid, corr_last, len_error}, 32'd0);
    check("midrst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("midrst_block_count", {16'd0, block_count}, 32'd0);
    bc_model = '0;
    repeat (2) tick();
    rst_b = 1'b1;
    repeat (10) tick();
    check("midrst_wait", {29'd0, state_dbg}, {29'd0, S_WAIT});
    run_block(1, 2, 2, 0);
    end_block(1'b0);

    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
